// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - decode/readreg hazard signals and pipeline enables
interface pipeline_hazard_ctrl_if;
  logic [2:0] num_Rm_id;
  logic [2:0] num_Rn_id;
  logic [2:0] used_RmRnRd_id;
  logic       loads_rr;
  logic [2:0] num_Rd_rr;
  logic       used_Rd_rr;
  logic       mem_busy;
  logic       flush;
  logic       update_pc;
  logic       update_if;
  logic       update_rr;
  logic       bubble_rr;

  modport master (
    output num_Rm_id, num_Rn_id, used_RmRnRd_id, loads_rr, num_Rd_rr, used_Rd_rr,
           mem_busy, flush,
    input  update_pc, update_if, update_rr, bubble_rr
  );

  modport slave (
    input  num_Rm_id, num_Rn_id, used_RmRnRd_id, loads_rr, num_Rd_rr, used_Rd_rr,
           mem_busy, flush,
    output update_pc, update_if, update_rr, bubble_rr
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use stall, memory freeze and flush control
// Enables are combinational from state, so a stall or bubble takes effect in the same cycle.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_hazard_ctrl_if.slave hif,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [7:0]           hazard_events
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    MEMW   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [7:0]       hzev_q, hzev_d;

  logic hz;
  logic take_hz;
  logic upc, uif, urr, bub;

  assign hz = hif.loads_rr & hif.used_Rd_rr &
              ((hif.used_RmRnRd_id[2] & (hif.num_Rm_id == hif.num_Rd_rr)) |
               (hif.used_RmRnRd_id[1] & (hif.num_Rn_id == hif.num_Rd_rr)));

  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    upc          = 1'b1;
    uif          = 1'b1;
    urr          = 1'b1;
    bub          = 1'b0;
    take_hz      = 1'b0;
    case (state_q)
      MEMW: begin
        if (hif.mem_busy) begin
          upc          = 1'b0;
          uif          = 1'b0;
          urr          = 1'b0;
          flush_pend_d = flush_pend_q | hif.flush;
        end else begin
          // A flush seen while frozen still has to kill the decoded instruction now.
          bub          = flush_pend_q | hif.flush;
          flush_pend_d = 1'b0;
          state_d      = RUN;
        end
      end
      LSTALL: begin
        if (hif.mem_busy) begin
          upc          = 1'b0;
          uif          = 1'b0;
          urr          = 1'b0;
          flush_pend_d = flush_pend_q | hif.flush;
          state_d      = MEMW;
        end else begin
          bub     = hif.flush;
          state_d = RUN;
        end
      end
      default: begin
        if (hif.mem_busy) begin
          upc          = 1'b0;
          uif          = 1'b0;
          urr          = 1'b0;
          flush_pend_d = flush_pend_q | hif.flush;
          state_d      = MEMW;
        end else if (hif.flush) begin
          bub = 1'b1;
        end else if (hz) begin
          upc     = 1'b0;
          uif     = 1'b0;
          bub     = 1'b1;
          take_hz = 1'b1;
          state_d = LSTALL;
        end
      end
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if (!upc && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
    hzev_d = hzev_q;
    if (take_hz) begin
      hzev_d = hzev_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RUN;
      flush_pend_q <= 1'b0;
      stall_q      <= '0;
      hzev_q       <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      stall_q      <= stall_d;
      hzev_q       <= hzev_d;
    end
  end

  // Enables are forced low while reset is held, independent of the clock.
  assign hif.update_pc = rst & upc;
  assign hif.update_if = rst & uif;
  assign hif.update_rr = rst & urr;
  assign hif.bubble_rr = rst & bub;

  assign stall_cycles  = stall_q;
  assign hazard_events = hzev_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - vector table plus corner sequences for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] stall_cycles;
  logic [7:0] hazard_events;

  pipeline_hazard_ctrl_if hif ();

  pipeline_hazard_ctrl #(.CNT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .hif           (hif),
    .stall_cycles  (stall_cycles),
    .hazard_events (hazard_events)
  );

  always #5 clk = ~clk;

  // kind: 0 idle, 1 Rm load-use, 2 Rn match but Rn unused, 3 Rn load-use,
  //       4 load without Rd write, 5 non-load match
  typedef struct {
    string      name;
    int         kind;
    logic       busy;
    logic       flush;
    logic [3:0] exp_out;
    int         exp_st;
    int         exp_hz;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] outs;
    int         st;
    int         hz;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;

  function automatic vec_t mk(string n, int k, logic b, logic f, logic [3:0] o, int s, int h);
    vec_t v;
    v.name = n; v.kind = k; v.busy = b; v.flush = f;
    v.exp_out = o; v.exp_st = s; v.exp_hz = h;
    return v;
  endfunction

  task automatic chk(string n, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  task automatic drive(int k, logic b, logic f);
    hif.num_Rm_id = 3'd0; hif.num_Rn_id = 3'd0; hif.used_RmRnRd_id = 3'b000;
    hif.loads_rr = 1'b0; hif.num_Rd_rr = 3'd0; hif.used_Rd_rr = 1'b0;
    case (k)
      1: begin hif.num_Rm_id = 3'd3; hif.used_RmRnRd_id = 3'b100;
               hif.loads_rr = 1'b1; hif.num_Rd_rr = 3'd3; hif.used_Rd_rr = 1'b1; end
      2: begin hif.num_Rm_id = 3'd5; hif.num_Rn_id = 3'd3; hif.used_RmRnRd_id = 3'b001;
               hif.loads_rr = 1'b1; hif.num_Rd_rr = 3'd3; hif.used_Rd_rr = 1'b1; end
      3: begin hif.num_Rn_id = 3'd3; hif.used_RmRnRd_id = 3'b010;
               hif.loads_rr = 1'b1; hif.num_Rd_rr = 3'd3; hif.used_Rd_rr = 1'b1; end
      4: begin hif.num_Rm_id = 3'd3; hif.used_RmRnRd_id = 3'b100;
               hif.loads_rr = 1'b1; hif.num_Rd_rr = 3'd3; hif.used_Rd_rr = 1'b0; end
      5: begin hif.num_Rm_id = 3'd3; hif.used_RmRnRd_id = 3'b100;
               hif.loads_rr = 1'b0; hif.num_Rd_rr = 3'd3; hif.used_Rd_rr = 1'b1; end
      default: ;
    endcase
    hif.mem_busy = b;
    hif.flush    = f;
  endtask

  function automatic logic [3:0] outs();
    return {hif.update_pc, hif.update_if, hif.update_rr, hif.bubble_rr};
  endfunction

  // Called at posedge+1; leaves time at the next posedge+1.
  task automatic step(vec_t v);
    exp_t e;
    drive(v.kind, v.busy, v.flush);
    e.name = v.name; e.outs = v.exp_out; e.st = v.exp_st; e.hz = v.exp_hz;
    sbq.push_back(e);
    @(negedge clk);
    e = sbq.pop_front();
    chk({e.name, "/outs"}, int'(outs()), int'(e.outs));
    @(posedge clk); #1;
    chk({e.name, "/stall"}, int'(stall_cycles), e.st);
    chk({e.name, "/hzev"}, int'(hazard_events), e.hz);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    vecs.push_back(mk("idle",          0, 0, 0, 4'b1110, 0, 0));
    vecs.push_back(mk("rm_hz",         1, 0, 0, 4'b0011, 1, 1));
    vecs.push_back(mk("lstall_norecheck", 1, 0, 0, 4'b1110, 1, 1));
    vecs.push_back(mk("rn_unused",     2, 0, 0, 4'b1110, 1, 1));
    vecs.push_back(mk("hz_and_flush",  1, 0, 1, 4'b1111, 1, 1));
    vecs.push_back(mk("rn_hz",         3, 0, 0, 4'b0011, 2, 2));
    vecs.push_back(mk("lstall_flush",  3, 0, 1, 4'b1111, 2, 2));
    vecs.push_back(mk("busy1",         0, 1, 0, 4'b0000, 3, 2));
    vecs.push_back(mk("busy2_flush",   0, 1, 1, 4'b0000, 4, 2));
    vecs.push_back(mk("busy3",         0, 1, 0, 4'b0000, 5, 2));
    vecs.push_back(mk("busy4",         0, 1, 0, 4'b0000, 6, 2));
    vecs.push_back(mk("memw_release",  0, 0, 0, 4'b1111, 6, 2));
    vecs.push_back(mk("rm_hz2",        1, 0, 0, 4'b0011, 7, 3));
    vecs.push_back(mk("lstall_busy",   1, 1, 0, 4'b0000, 8, 3));
    vecs.push_back(mk("memw_ignore_hz", 1, 0, 0, 4'b1110, 8, 3));
    vecs.push_back(mk("rm_hz3",        1, 0, 0, 4'b0011, 9, 4));
    vecs.push_back(mk("lstall_idle",   0, 0, 0, 4'b1110, 9, 4));
    vecs.push_back(mk("run_busy_flush", 0, 1, 1, 4'b0000, 10, 4));
    vecs.push_back(mk("memw_pend",     0, 0, 0, 4'b1111, 10, 4));
    vecs.push_back(mk("no_rd_write",   4, 0, 0, 4'b1110, 10, 4));
    vecs.push_back(mk("not_load",      5, 0, 0, 4'b1110, 10, 4));
    vecs.push_back(mk("busy_nopend",   0, 1, 0, 4'b0000, 11, 4));
    vecs.push_back(mk("memw_flush_now", 0, 0, 1, 4'b1111, 11, 4));
    vecs.push_back(mk("after_flush",   0, 0, 0, 4'b1110, 11, 4));

    drive(0, 1'b0, 1'b0);
    #12;
    chk("reset/outs", int'(outs()), 0);
    chk("reset/stall", int'(stall_cycles), 0);
    chk("reset/hzev", int'(hazard_events), 0);

    do_reset();
    foreach (vecs[i]) step(vecs[i]);

    // stall counter saturation
    do_reset();
    drive(0, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
    end
    chk("sat/outs", int'(outs()), 0);
    chk("sat/stall", int'(stall_cycles), 8'hFF);

    // hazard event wrap
    do_reset();
    for (int i = 0; i < 256; i++) begin
      drive(1, 1'b0, 1'b0);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0);
      @(posedge clk); #1;
      if (i == 254) chk("wrap/hzev_ff", int'(hazard_events), 8'hFF);
    end
    chk("wrap/hzev_0", int'(hazard_events), 0);
    chk("wrap/stall_sat", int'(stall_cycles), 8'hFF);

    // asynchronous reset inside MEMW with a pending flush
    do_reset();
    drive(0, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0);
    #1;
    chk("rstmemw/pre", int'(outs()), 4'b1111);
    rst = 1'b0;
    #1;
    chk("rstmemw/outs", int'(outs()), 0);
    chk("rstmemw/stall", int'(stall_cycles), 0);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmemw/run", int'(outs()), 4'b1110);
    @(posedge clk); #1;
    chk("rstmemw/run2", int'(outs()), 4'b1110);
    chk("rstmemw/stall2", int'(stall_cycles), 0);

    chk("sb/empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of the stall-cycle counter (8..32).
REQ-002 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-low reset.
REQ-005 num_Rm_id  in  3  Rm number of the decoded instruction about to enter the readreg register.
REQ-006 num_Rn_id  in  3  Rn number of the decoded instruction.
REQ-007 used_RmRnRd_id  in  3  [2] Rm read, [1] Rn read, [0] Rd written (decoded instruction).
REQ-008 loads_rr  in  1  instruction currently held in the readreg register is a load (control bit 8).
REQ-009 num_Rd_rr  in  3  Rd number held in the readreg register.
REQ-010 used_Rd_rr  in  1  the readreg instruction writes Rd (its used_RmRnRd[0]).
REQ-011 mem_busy  in  1  data memory not ready; whole front end must freeze.
REQ-012 flush  in  1  taken branch; discard the decoded instruction (single-cycle pulse).
REQ-013 update_pc  out  1  PC register enable.
REQ-014 update_if  out  1  fetch/decode register enable.
REQ-015 update_rr  out  1  enable for the readreg pipeline register.
REQ-016 bubble_rr  out  1  selects all-zero control into the readreg register (NOP injection).
REQ-017 stall_cycles  out  CNT_W  saturating count of cycles with update_pc=0.
REQ-018 hazard_events  out  8  wrapping count of load-use stalls taken.

Function
REQ-019 The hazard condition SHALL be hz = loads_rr & used_Rd_rr & ((used_RmRnRd_id[2] & num_Rm_id==num_Rd_rr) | (used_RmRnRd_id[1] & num_Rn_id==num_Rd_rr)).
REQ-020 The FSM SHALL have the states RUN, LSTALL and MEMW, with registered state and flush_pend.
REQ-021 RUN, mem_busy=1: all updates SHALL be 0 and bubble_rr 0; next state MEMW; a concurrent flush SHALL set flush_pend.
REQ-022 RUN, mem_busy=0, flush=1: all updates SHALL be 1 and bubble_rr 1; hz is ignored; next state RUN.
REQ-023 RUN, mem_busy=0, flush=0, hz=1: update_pc=0, update_if=0, update_rr=1, bubble_rr=1; next state LSTALL; hazard_events SHALL increment.
REQ-024 RUN, no event: all updates SHALL be 1 and bubble_rr 0.
REQ-025 LSTALL SHALL last exactly one cycle; hz is not re-evaluated; outputs SHALL follow RUN rules for mem_busy/flush, otherwise all updates 1 and bubble_rr 0; next state RUN (or MEMW if mem_busy).
REQ-026 MEMW, mem_busy=1: all updates SHALL be 0; flush=1 SHALL set flush_pend.
REQ-027 MEMW, mem_busy=0: all updates SHALL be 1, with bubble_rr = flush_pend | flush; flush_pend SHALL clear; next state RUN; hz is not acted on in this cycle.
REQ-028 Outputs SHALL be combinational from state, flush_pend and inputs, with no additional latency.
REQ-029 stall_cycles SHALL increment on each clock with update_pc=0 and SHALL hold at all-ones (no wrap).
REQ-030 hazard_events SHALL wrap from 8'hFF to 8'h00.

Reset
REQ-031 While rst=0, state SHALL be RUN, flush_pend 0 and counters 0; update_pc/if/rr SHALL be 0 and bubble_rr 0, asynchronously.
REQ-032 Reset asserted mid-LSTALL or mid-MEMW SHALL discard the state and flush_pend immediately.
REQ-033 The first edge after rst deasserts SHALL evaluate RUN rules.

Verification
REQ-034 Load R3 in rr, ID reads Rm=R3 -> one cycle with pc/if=0, rr=1, bubble=1; hazard_events=1; stall_cycles=1; next cycle all updates 1.
REQ-035 Load R3 in rr, ID reads Rn=R3 with used bit1=0 -> no stall; counters stay 0.
REQ-036 mem_busy high 4 cycles with a flush pulse in cycle 2 -> 4 frozen cycles, then one cycle updates=1 with bubble=1; stall_cycles=4.
REQ-037 hz and flush in the same cycle -> updates=1, bubble=1, hazard_events unchanged.
REQ-038 CNT_W=8, 300 mem_busy cycles -> stall_cycles=8'hFF; 256 load-use stalls -> hazard_events=0.
REQ-039 rst pulsed low during MEMW with flush_pend=1 -> outputs 0 immediately; after release, RUN with bubble_rr=0.
